modexp_sm: RTL

// - Parametrised modular exponentiator: c = m^e mod n, left-to-right square-and-multiply.
// - Sits beside modexp as its successor. Adds independent exponent width, a runtime

---
 rtl/modexp_pkg.sv | 15 +
 rtl/modmul.sv | 70 +++++++
 rtl/modexp_sm.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/modexp_pkg.sv
// Shared types for the square-and-multiply modular exponentiator.
package modexp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SQ_GO,
        SQ_WAIT,
        MUL_GO,
        MUL_WAIT,
        DONE,
        DRAIN
    } state_t;

endpackage

// File: rtl/modmul.sv
// Bit-serial modular multiplier p = a*b mod n (a, b < n); W cycles after start, then ready=1.
// start is honoured only while ready=1; ready drops the following cycle and rises with p valid.
module modmul #(
    parameter int W = 2048
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic         ready,
    output logic [W-1:0] p
);

    localparam int CW = $clog2(W + 1);

    logic          busy;
    logic [CW-1:0] cnt;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic [W-1:0]  rn;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_nxt;
    logic          unused_msb;

    logic [W:0] dbl;
    logic [W:0] dbl_red;
    logic [W:0] sum;
    logic [W:0] sum_red;

    // Horner step over b from MSB: acc = 2*acc (+a); each partial stays < 2n so one subtract reduces it.
    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= {1'b0, rn}) ? dbl - {1'b0, rn} : dbl;
        sum     = dbl_red + (rb[W-1] ? {1'b0, ra} : '0);
        sum_red = (sum >= {1'b0, rn}) ? sum - {1'b0, rn} : sum;
    end

    assign {unused_msb, acc_nxt} = sum_red;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            ra   <= '0;
            rb   <= '0;
            rn   <= '0;
            acc  <= '0;
        end else if (!busy && start) begin
            ra   <= a;
            rb   <= b;
            rn   <= n;
            acc  <= '0;
            cnt  <= CW'(W);
            busy <= 1'b1;
        end else if (busy) begin
            acc <= acc_nxt;
            rb  <= rb << 1;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign ready = !busy;
    assign p     = acc;

endmodule

// File: rtl/modexp_sm.sv
// c = m^e mod n, left-to-right square-and-multiply over e[ebits-1:0] on one shared modmul.
// Latency: 2 cycles for trivial cases, else ~ebits*(1|2)*(W+2) cycles; start ignored while ready=0.
module modexp_sm
    import modexp_pkg::*;
#(
    parameter int W  = 2048,
    parameter int EW = 2048,
    parameter int LW = $clog2(EW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          mode_ct,
    input  logic [LW-1:0] ebits,
    input  logic [W-1:0]  m,
    input  logic [EW-1:0] e,
    input  logic [W-1:0]  n,
    output logic          ready,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  c
);

    localparam logic [W-1:0] ONE = W'(1);

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  c_r;
    logic [W-1:0]  m_r;
    logic [W-1:0]  n_r;
    logic [EW-1:0] e_r;
    logic [LW-1:0] eb_r;
    logic [LW-1:0] i_r;
    logic          ct_r;
    logic          err_r;

    logic [LW-1:0] eb_in;
    logic          e_bit;
    logic          mul_start;
    logic          mul_sel_m;
    logic          mul_ready;
    logic [W-1:0]  mul_b;
    logic [W-1:0]  mul_p;
    logic          abort_hit;

    assign eb_in     = (ebits > LW'(EW)) ? LW'(EW) : ebits;
    assign e_bit     = |(e_r & ({{(EW-1){1'b0}}, 1'b1} << i_r));
    assign abort_hit = abort && (state != IDLE);
    assign mul_b     = mul_sel_m ? m_r : c_r;

    modmul #(.W(W)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (c_r),
        .b     (mul_b),
        .n     (n_r),
        .ready (mul_ready),
        .p     (mul_p)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        mul_sel_m = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = CHECK;
            end
            CHECK: begin
                if (n_r == '0 || n_r == ONE || eb_r == '0 || e_r == '0) state_nxt = DONE;
                else                                                    state_nxt = SQ_GO;
            end
            SQ_GO: begin
                if (mul_ready) begin
                    mul_start = 1'b1;
                    state_nxt = SQ_WAIT;
                end
            end
            SQ_WAIT: begin
                if (mul_ready) begin
                    if (e_bit || ct_r)   state_nxt = MUL_GO;
                    else if (i_r == '0)  state_nxt = DONE;
                    else                 state_nxt = SQ_GO;
                end
            end
            MUL_GO: begin
                mul_sel_m = 1'b1;
                if (mul_ready) begin
                    mul_start = 1'b1;
                    state_nxt = MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                if (mul_ready) begin
                    if (i_r == '0) state_nxt = DONE;
                    else           state_nxt = SQ_GO;
                end
            end
            DONE:    state_nxt = IDLE;
            DRAIN: begin
                if (mul_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // An in-flight multiply is left to finish in DRAIN so modmul is idle before the next start.
        if (abort_hit && state != DRAIN) begin
            state_nxt = DRAIN;
            mul_start = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_r   <= ONE;
            m_r   <= '0;
            n_r   <= '0;
            e_r   <= '0;
            eb_r  <= '0;
            i_r   <= '0;
            ct_r  <= 1'b0;
            err_r <= 1'b0;
        end else if (!abort_hit) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_r   <= m;
                        e_r   <= e;
                        n_r   <= n;
                        eb_r  <= eb_in;
                        ct_r  <= mode_ct;
                        err_r <= 1'b0;
                    end
                end
                CHECK: begin
                    if (n_r == '0) begin
                        err_r <= 1'b1;
                        c_r   <= '0;
                    end else if (n_r == ONE) begin
                        c_r <= '0;
                    end else begin
                        c_r <= ONE;
                        if (eb_r != '0 && e_r != '0) i_r <= eb_r - LW'(1);
                    end
                end
                SQ_WAIT: begin
                    if (mul_ready) begin
                        c_r <= mul_p;
                        if (!(e_bit || ct_r) && i_r != '0) i_r <= i_r - LW'(1);
                    end
                end
                MUL_WAIT: begin
                    if (mul_ready) begin
                        // Constant-time dummy multiply: product computed but discarded.
                        if (e_bit) c_r <= mul_p;
                        if (i_r != '0) i_r <= i_r - LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);
    assign err   = err_r;
    assign c     = c_r;

endmodule
